shift_seq_ctrl: RTL
===================

Name: shift_seq_ctrl

Overview:
- Iterative sequencer for a 32-bit logarithmic shifter: applies one power-of-two stage (16, 8, 4, 2, 1) per clock instead of the full 5-stage combinational cascade.
- Shortens the critical path of the ALU shift path. Sits between the execute-stage issue logic and writeback.
- Valid/ready handshake on both sides; supports SLL, SRL, SRA and ROL.

Parameters:
- WIDTH, 32, operand/result width; must equal 2**SHW.
- SHW, 5, shift-amount width.
- SKIP_ZERO, 1, 1: stages whose shamt bit is 0 are skipped; 0: every stage takes one cycle (fixed latency SHW).

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- in_operand  input  WIDTH  value to shift.
- in_shamt  input  SHW  shift amount.
- in_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROL.
- flush  input  1  synchronous abort; drops any in-flight op.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_result  output  WIDTH  shifted value.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- States:
  - IDLE: in_ready=1, out_valid=0.
  - SHIFT: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Reset (reset=0, asynchronous):
  - state=IDLE; working register, remaining-shamt register and op register cleared to 0.
  - out_result=0, out_valid=0, busy=0, in_ready=1.
- Accept: IDLE with in_valid=1 at a rising edge latches operand into the working register, shamt into rem, op into the op register, then goes to SHIFT.
- SHIFT, SKIP_ZERO=1, each cycle:
  - Select k = highest set bit of rem.
  - Shift the working register by 2**k per op:
    - SLL: zero fill.
    - SRL: zero fill.
    - SRA: fill with bit WIDTH-1 of the current working value.
    - ROL: wrap-around.
  - Clear rem[k]. If the new rem==0, go to DONE.
- rem==0 on entry to SHIFT (shamt=0): no shift; go to DONE after one cycle.
- SHIFT, SKIP_ZERO=0:
  - Stage counter walks k = SHW-1 down to 0, one cycle each.
  - Apply the shift only if rem[k]=1; go to DONE after k=0.
- Latency from the accept edge to out_valid high:
  - SKIP_ZERO=1: max(1, popcount(shamt)) cycles.
  - SKIP_ZERO=0: SHW cycles.
- Stage order (high to low) does not affect the result; ROL/SRA results must match a single combinational shift by shamt.
- DONE:
  - out_result = working register, held stable while out_ready=0.
  - out_valid && out_ready at an edge returns to IDLE. A new request is accepted no earlier than the following cycle (no same-cycle turnaround).
- out_result in IDLE/SHIFT: shows the working register; not qualified.
- flush=1:
  - Next state is IDLE from any state; takes priority over accept, shift and output handshake.
  - Working registers are not cleared.
  - A DONE-state out_valid && out_ready in the same cycle counts as delivered.
  - flush in IDLE with in_valid=1: request not accepted.
- Reset mid-operation: immediate return to reset values; the in-flight op is lost with no output.
- in_* inputs are ignored outside IDLE; the requester holds them until in_ready && in_valid.
- busy = (state != IDLE).

Test Plan:
- SLL, operand 0x0000_0001, shamt 31, SKIP_ZERO=1 -> out_valid 5 cycles after accept, out_result 0x8000_0000.
- SRA, operand 0x8000_0000, shamt 4 -> out_valid after 1 cycle, out_result 0xF800_0000. SRL with the same inputs -> 0x0800_0000.
- ROL, operand 0x8000_0001, shamt 1 -> 0x0000_0003. ROL 0x1234_5678 by 20 (2 stages) -> 0x6781_2345 after 2 cycles.
- shamt 0, any op, operand 0xDEAD_BEEF -> out_result 0xDEAD_BEEF after 1 cycle. Same with SKIP_ZERO=0 -> 5 cycles.
- Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid and out_result stable, in_ready=0, second in_valid not accepted. out_ready=1 -> IDLE next cycle, then the second request is accepted.
- flush at the 2nd cycle of SLL by 31, and separately reset=0 mid-SHIFT -> IDLE next edge (reset: immediately), out_valid never asserted. Next request 0x1 SLL 3 -> 0x0000_0008.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// Iterative 32-bit shift sequencer: applies one power-of-two stage per clock
// for SLL/SRL/SRA/ROL with valid/ready handshakes on request and result.
module shift_seq_ctrl #(
  parameter int WIDTH     = 32,
  parameter int SHW       = 5,
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_operand,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_op,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             busy
);

  localparam int KW = (SHW > 1) ? $clog2(SHW) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] work_r, work_s;
  logic [SHW-1:0]   rem_r, rem_s;
  logic [1:0]       op_r, op_s;
  logic [KW-1:0]    stage_r, stage_s;
  logic [KW-1:0]    k_s;
  logic             in_ready_r, out_valid_r, busy_r;

  // One shifter stage: move v by 2**k; SRA fills from the current MSB.
  function automatic logic [WIDTH-1:0] shift_stage(
    input logic [WIDTH-1:0] v,
    input logic [1:0]       op,
    input logic [KW-1:0]    k
  );
    logic [SHW-1:0]     amt;
    logic [2*WIDTH-1:0] dbl;
    logic [WIDTH-1:0]   r;
    amt = {{(SHW-1){1'b0}}, 1'b1} << k;
    dbl = {v, v} << amt;
    case (op)
      2'b00:   r = v << amt;
      2'b01:   r = v >> amt;
      2'b10:   r = $signed(v) >>> amt;
      2'b11:   r = dbl[2*WIDTH-1:WIDTH];
      default: r = v;
    endcase
    return r;
  endfunction

  // Index of the highest set bit of the remaining shift amount.
  always_comb begin
    k_s = {KW{1'b0}};
    for (int i = 0; i < SHW; i++) begin
      if (rem_r[i]) begin
        k_s = KW'(i);
      end else begin
        k_s = k_s;
      end
    end
  end

  // Next-state logic; flush overrides accept, shifting and the result handshake.
  always_comb begin
    state_s = state_r;
    work_s  = work_r;
    rem_s   = rem_r;
    op_s    = op_r;
    stage_s = stage_r;
    if (flush) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            work_s  = in_operand;
            rem_s   = in_shamt;
            op_s    = in_op;
            stage_s = KW'(SHW - 1);
            state_s = SHIFT;
          end else begin
            state_s = IDLE;
          end
        end
        SHIFT: begin
          if (SKIP_ZERO) begin
            if (rem_r == {SHW{1'b0}}) begin
              state_s = DONE;
            end else begin
              work_s = shift_stage(work_r, op_r, k_s);
              rem_s  = rem_r & ~({{(SHW-1){1'b0}}, 1'b1} << k_s);
              if (rem_s == {SHW{1'b0}}) begin
                state_s = DONE;
              end else begin
                state_s = SHIFT;
              end
            end
          end else begin
            // Fixed latency: visit every stage, shift only where the bit is set.
            if (rem_r[stage_r]) begin
              work_s = shift_stage(work_r, op_r, stage_r);
            end else begin
              work_s = work_r;
            end
            if (stage_r == {KW{1'b0}}) begin
              state_s = DONE;
            end else begin
              stage_s = stage_r - {{(KW-1){1'b0}}, 1'b1};
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_s = IDLE;
          end else begin
            state_s = DONE;
          end
        end
        default: state_s = IDLE;
      endcase
    end
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      work_r      <= {WIDTH{1'b0}};
      rem_r       <= {SHW{1'b0}};
      op_r        <= 2'b00;
      stage_r     <= {KW{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      work_r      <= work_s;
      rem_r       <= rem_s;
      op_r        <= op_s;
      stage_r     <= stage_s;
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
      busy_r      <= (state_s != IDLE);
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign busy       = busy_r;
  assign out_result = work_r;

endmodule
